// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
// tmr_pkg : shared states, voter codes and defaults for TMR recovery control
// Revision: 1.0
// ============================================================================
package tmr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STALL    = 3'd1,
        ST_COPY     = 3'd2,
        ST_PCLOAD   = 3'd3,
        ST_RESUME   = 3'd4,
        ST_ROLLBACK = 3'd5,
        ST_FATAL    = 3'd6
    } tmr_state_t;

    // Voter_state bit order is {AB,BC,AC}
    localparam logic [2:0] VS_HEALTHY = 3'b111;
    localparam logic [2:0] VS_A_FAULT = 3'b010;
    localparam logic [2:0] VS_B_FAULT = 3'b001;
    localparam logic [2:0] VS_C_FAULT = 3'b100;

    localparam int SETTLE_CYCLES_DEF = 2;
    localparam int MAX_RETRY_DEF     = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_fault_decode.sv
`default_nettype none
// ============================================================================
// tmr_fault_decode : voter agreement flags -> faulty core, donor, no-majority
// Revision: 1.0
// ============================================================================
module tmr_fault_decode
    import tmr_pkg::*;
(
    input  logic [2:0] voter_state,
    output logic [2:0] faulty,
    output logic [2:0] donor,
    output logic       healthy,
    output logic       no_majority
);

    // One-hot vectors are {C,B,A}; donor is the lowest-lettered healthy core
    always_comb begin
        faulty      = 3'b000;
        donor       = 3'b000;
        healthy     = 1'b0;
        no_majority = 1'b0;
        case (voter_state)
            VS_HEALTHY: healthy = 1'b1;
            VS_A_FAULT: begin
                faulty = 3'b001;
                donor  = 3'b010;
            end
            VS_B_FAULT: begin
                faulty = 3'b010;
                donor  = 3'b001;
            end
            VS_C_FAULT: begin
                faulty = 3'b100;
                donor  = 3'b001;
            end
            default:    no_majority = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tmr_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// tmr_recovery_ctrl : stall, register copy, PC reload and rollback for TMR cores
// Revision: 1.0
// ============================================================================
module tmr_recovery_ctrl
    import tmr_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic [2:0]  Voter_state,
    input  logic [31:0] PC_Top,
    input  logic [31:0] PC_Top_rollback,
    input  logic [31:0] Sync_rdata_A,
    input  logic [31:0] Sync_rdata_B,
    input  logic [31:0] Sync_rdata_C,
    input  logic        Clear_fatal,
    output logic        Stall,
    output logic [4:0]  Sync_addr,
    output logic [31:0] Sync_wdata,
    output logic [2:0]  Sync_we,
    output logic [2:0]  PC_load,
    output logic [31:0] PC_load_value,
    output logic        Rollback,
    output logic        Fatal,
    output logic        Busy,
    output logic [2:0]  Fault_core,
    output logic [7:0]  Fault_count_A,
    output logic [7:0]  Fault_count_B,
    output logic [7:0]  Fault_count_C
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);
    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    tmr_state_t  state;
    logic [7:0]  settle_cnt;
    logic [7:0]  retry_cnt;
    logic [31:0] pc_snapshot;
    logic [2:0]  donor;
    logic [31:0] donor_data;

    logic [2:0]  dec_faulty;
    logic [2:0]  dec_donor;
    logic        dec_healthy;
    logic        dec_no_majority;

    tmr_fault_decode u_decode (
        .voter_state (Voter_state),
        .faulty      (dec_faulty),
        .donor       (dec_donor),
        .healthy     (dec_healthy),
        .no_majority (dec_no_majority)
    );

    // Register files are read asynchronously, so copy data follows Sync_addr
    always_comb begin
        donor_data = 32'd0;
        case (donor)
            3'b001:  donor_data = Sync_rdata_A;
            3'b010:  donor_data = Sync_rdata_B;
            3'b100:  donor_data = Sync_rdata_C;
            default: donor_data = 32'd0;
        endcase
    end

    assign Sync_wdata = (state == ST_COPY) ? donor_data : 32'd0;
    assign Busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state         <= ST_IDLE;
            settle_cnt    <= 8'd0;
            retry_cnt     <= 8'd0;
            pc_snapshot   <= 32'd0;
            donor         <= 3'b000;
            Stall         <= 1'b0;
            Sync_addr     <= 5'd0;
            Sync_we       <= 3'b000;
            PC_load       <= 3'b000;
            PC_load_value <= 32'd0;
            Rollback      <= 1'b0;
            Fatal         <= 1'b0;
            Fault_core    <= 3'b000;
            Fault_count_A <= 8'd0;
            Fault_count_B <= 8'd0;
            Fault_count_C <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dec_healthy) begin
                        retry_cnt <= 8'd0;
                    end else if (dec_no_majority) begin
                        Stall <= 1'b1;
                        if (retry_cnt == RETRY_LIMIT) begin
                            state <= ST_FATAL;
                            Fatal <= 1'b1;
                        end else begin
                            state         <= ST_ROLLBACK;
                            Rollback      <= 1'b1;
                            PC_load       <= 3'b111;
                            PC_load_value <= PC_Top_rollback;
                            retry_cnt     <= retry_cnt + 8'd1;
                        end
                    end else begin
                        state       <= ST_STALL;
                        Stall       <= 1'b1;
                        Fault_core  <= dec_faulty;
                        donor       <= dec_donor;
                        pc_snapshot <= PC_Top;
                        settle_cnt  <= 8'd0;
                    end
                end
                // One freeze cycle followed by SETTLE_CYCLES settle cycles
                ST_STALL: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state     <= ST_COPY;
                        Sync_addr <= 5'd1;
                        Sync_we   <= Fault_core;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_COPY: begin
                    if (Sync_addr == 5'd31) begin
                        state         <= ST_PCLOAD;
                        Sync_addr     <= 5'd0;
                        Sync_we       <= 3'b000;
                        PC_load       <= Fault_core;
                        PC_load_value <= pc_snapshot;
                    end else begin
                        Sync_addr <= Sync_addr + 5'd1;
                    end
                end
                ST_PCLOAD: begin
                    state         <= ST_RESUME;
                    PC_load       <= 3'b000;
                    PC_load_value <= 32'd0;
                    if (Fault_core[0]) Fault_count_A <= sat_inc8(Fault_count_A);
                    if (Fault_core[1]) Fault_count_B <= sat_inc8(Fault_count_B);
                    if (Fault_core[2]) Fault_count_C <= sat_inc8(Fault_count_C);
                end
                ST_RESUME: begin
                    state      <= ST_IDLE;
                    Stall      <= 1'b0;
                    Fault_core <= 3'b000;
                end
                ST_ROLLBACK: begin
                    state         <= ST_IDLE;
                    Stall         <= 1'b0;
                    Rollback      <= 1'b0;
                    PC_load       <= 3'b000;
                    PC_load_value <= 32'd0;
                end
                ST_FATAL: begin
                    if (Clear_fatal) begin
                        state     <= ST_IDLE;
                        Stall     <= 1'b0;
                        Fatal     <= 1'b0;
                        retry_cnt <= 8'd0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
